// File: rtl/std_alu_arbiter.sv
// Round-robin arbiter sharing one combinational add/sub unit among NUM_REQ requesters.
// Accepts one operation at a time, executes it for one cycle, then holds the result until the consumer takes it.
module std_alu_arbiter #(
  parameter int WIDTH   = 32,
  parameter int NUM_REQ = 4,
  parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ-1:0]       req_sub,
  input  logic [NUM_REQ*WIDTH-1:0] req_left,
  input  logic [NUM_REQ*WIDTH-1:0] req_right,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic [WIDTH-1:0]         dp_left,
  output logic [WIDTH-1:0]         dp_right,
  output logic                     dp_sub,
  input  logic [WIDTH-1:0]         dp_out,
  output logic                     resp_valid,
  output logic [ID_W-1:0]          resp_id,
  output logic [WIDTH-1:0]         resp_data,
  input  logic                     resp_ready,
  output logic                     busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t             state;
  logic [ID_W-1:0]    rr_ptr;
  logic [ID_W-1:0]    id_r;
  logic [WIDTH-1:0]   left_r;
  logic [WIDTH-1:0]   right_r;
  logic               sub_r;
  logic [WIDTH-1:0]   res_r;
  logic               resp_valid_r;
  logic               busy_r;

  logic               win_found;
  logic [ID_W-1:0]    win_id;
  logic               accept;

  // Winner search starts at rr_ptr and wraps, so the last-served requester goes to the back.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!win_found && req_valid[(int'(rr_ptr) + k) % NUM_REQ]) begin
        win_found = 1'b1;
        win_id    = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
      end
    end
  end

  // Grant is withheld while reset is held so nothing looks accepted during reset.
  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = reset_n && (state == IDLE) && win_found && (win_id == ID_W'(i));
    end
  end

  assign accept = (state == IDLE) && win_found;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      rr_ptr       <= '0;
      id_r         <= '0;
      left_r       <= '0;
      right_r      <= '0;
      sub_r        <= 1'b0;
      res_r        <= '0;
      resp_valid_r <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            left_r  <= req_left[int'(win_id)*WIDTH +: WIDTH];
            right_r <= req_right[int'(win_id)*WIDTH +: WIDTH];
            sub_r   <= req_sub[win_id];
            id_r    <= win_id;
            busy_r  <= 1'b1;
            state   <= EXEC;
          end
        end
        EXEC: begin
          res_r        <= dp_out;
          resp_valid_r <= 1'b1;
          state        <= RESP;
        end
        RESP: begin
          if (resp_ready) begin
            rr_ptr       <= (id_r == ID_W'(NUM_REQ-1)) ? '0 : id_r + 1'b1;
            resp_valid_r <= 1'b0;
            busy_r       <= 1'b0;
            state        <= IDLE;
          end
        end
        default: begin
          resp_valid_r <= 1'b0;
          busy_r       <= 1'b0;
          state        <= IDLE;
        end
      endcase
    end
  end

  assign dp_left    = left_r;
  assign dp_right   = right_r;
  assign dp_sub     = sub_r;
  assign resp_valid = resp_valid_r;
  assign resp_id    = id_r;
  assign resp_data  = res_r;
  assign busy       = busy_r;

endmodule

// File: tb/tb_std_alu_arbiter.sv
// Randomized and directed bench for std_alu_arbiter against a transaction-level reference model.
module tb_std_alu_arbiter;
  localparam int WIDTH   = 32;
  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;

  logic                     clk = 1'b0;
  logic                     reset_n;
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_sub;
  logic [NUM_REQ*WIDTH-1:0] req_left;
  logic [NUM_REQ*WIDTH-1:0] req_right;
  logic [NUM_REQ-1:0]       req_ready;
  logic [WIDTH-1:0]         dp_left;
  logic [WIDTH-1:0]         dp_right;
  logic                     dp_sub;
  logic [WIDTH-1:0]         dp_out;
  logic                     resp_valid;
  logic [ID_W-1:0]          resp_id;
  logic [WIDTH-1:0]         resp_data;
  logic                     resp_ready;
  logic                     busy;

  logic [WIDTH-1:0] lefts  [NUM_REQ];
  logic [WIDTH-1:0] rights [NUM_REQ];
  logic             subs   [NUM_REQ];

  int n_tests = 0;
  int n_fail  = 0;
  int model_ptr = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // The shared arithmetic unit the arbiter drives.
  assign dp_out = dp_sub ? dp_left - dp_right : dp_left + dp_right;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_pack
    assign req_left[g*WIDTH +: WIDTH]  = lefts[g];
    assign req_right[g*WIDTH +: WIDTH] = rights[g];
    assign req_sub[g]                  = subs[g];
  end

  std_alu_arbiter #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_sub(req_sub),
    .req_left(req_left), .req_right(req_right), .req_ready(req_ready),
    .dp_left(dp_left), .dp_right(dp_right), .dp_sub(dp_sub), .dp_out(dp_out),
    .resp_valid(resp_valid), .resp_id(resp_id), .resp_data(resp_data),
    .resp_ready(resp_ready), .busy(busy)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Valid requester closest (cyclically) at or after the pointer.
  function automatic int pick(input logic [NUM_REQ-1:0] mask, input int ptr);
    int best;
    int bestd;
    best  = -1;
    bestd = NUM_REQ;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (mask[i] && ((i - ptr + NUM_REQ) % NUM_REQ) < bestd) begin
        bestd = (i - ptr + NUM_REQ) % NUM_REQ;
        best  = i;
      end
    end
    return best;
  endfunction

  // Called one tick after a rising edge with the DUT in IDLE; returns in the next IDLE cycle.
  task automatic do_op(input logic [NUM_REQ-1:0] mask, input int stall,
                       output int w, output int acc_cyc);
    logic [WIDTH-1:0] exp_res;
    logic [ID_W-1:0]  held_id;
    logic [WIDTH-1:0] held_data;
    req_valid = mask;
    #1;
    w = pick(mask, model_ptr);
    chk("idle_busy", busy, 0);
    chk("grant", req_ready, NUM_REQ'(1) << w);
    acc_cyc = cyc;
    exp_res = subs[w] ? lefts[w] - rights[w] : lefts[w] + rights[w];
    resp_ready = 1'b0;
    step;
    req_valid[w] = 1'b0;
    #1;
    chk("exec_busy", busy, 1);
    chk("exec_rvalid", resp_valid, 0);
    chk("exec_ready", req_ready, 0);
    chk("dp_left", dp_left, lefts[w]);
    chk("dp_right", dp_right, rights[w]);
    chk("dp_sub", dp_sub, subs[w]);
    step;
    chk("resp_valid", resp_valid, 1);
    chk("resp_id", resp_id, w);
    chk("resp_data", resp_data, exp_res);
    chk("resp_busy", busy, 1);
    held_id   = resp_id;
    held_data = resp_data;
    for (int s = 0; s < stall; s++) begin
      #1;
      chk("stall_valid", resp_valid, 1);
      chk("stall_id", resp_id, held_id);
      chk("stall_data", resp_data, held_data);
      chk("stall_ready", req_ready, 0);
      step;
    end
    resp_ready = 1'b1;
    req_valid  = req_valid | mask;
    #1;
    chk("hs_ready", req_ready, 0);
    chk("hs_data", resp_data, exp_res);
    step;
    req_valid  = req_valid & ~(NUM_REQ'(1) << w);
    resp_ready = 1'b0;
    model_ptr  = (w + 1) % NUM_REQ;
    #1;
    chk("back_idle_busy", busy, 0);
    chk("back_idle_rvalid", resp_valid, 0);
  endtask

  task automatic rand_operands;
    for (int i = 0; i < NUM_REQ; i++) begin
      lefts[i]  = $urandom;
      rights[i] = $urandom;
      subs[i]   = $urandom_range(0, 1);
    end
  endtask

  int w, t0, t1;
  logic [NUM_REQ-1:0] m;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n    = 1'b0;
    req_valid  = '0;
    resp_ready = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      lefts[i] = '0; rights[i] = '0; subs[i] = 1'b0;
    end
    step; step;
    chk("rst_busy", busy, 0);
    chk("rst_rvalid", resp_valid, 0);
    chk("rst_rid", resp_id, 0);
    chk("rst_rdata", resp_data, 0);
    chk("rst_dpl", dp_left, 0);
    chk("rst_dpr", dp_right, 0);
    chk("rst_dps", dp_sub, 0);
    chk("rst_ready", req_ready, 0);
    reset_n = 1'b1;
    step;

    // Single add
    lefts[0] = 5; rights[0] = 3; subs[0] = 1'b0;
    do_op(4'b0001, 0, w, t0);
    chk("add_id", w, 0);

    // Wrap-around arithmetic
    lefts[1] = 0; rights[1] = 1; subs[1] = 1'b1;
    do_op(4'b0010, 0, w, t0);
    lefts[2] = 32'hFFFF_FFFF; rights[2] = 2; subs[2] = 1'b0;
    do_op(4'b0100, 0, w, t0);
    lefts[1] = 32'hFFFF_FFFF; rights[1] = 2; subs[1] = 1'b0;
    do_op(4'b0010, 0, w, t0);
    chk("wrap_id", w, 1);

    // Fairness with all requesters valid, pointer brought to 0 first
    do_op(4'b1000, 0, w, t0);
    rand_operands();
    t0 = -1;
    for (int k = 0; k < 6; k++) begin
      do_op(4'b1111, 0, w, t1);
      chk("fair_order", w, k % NUM_REQ);
      if (t0 >= 0) chk("fair_spacing", t1 - t0, 3);
      t0 = t1;
    end

    // Pointer wrap
    do_op(4'b1000, 0, w, t0);
    chk("pw_serve3", w, 3);
    do_op(4'b0100, 0, w, t0);
    chk("pw_only2", w, 2);
    do_op(4'b0101, 0, w, t0);
    chk("pw_zero_first", w, 0);

    // Backpressure, leaves pointer at 2
    do_op(4'b0010, 5, w, t0);
    chk("bp_id", w, 1);

    // Reset during EXEC
    req_valid = 4'b0100;
    #1;
    chk("rx_grant", req_ready, 4'b0100);
    step;
    reset_n   = 1'b0;
    req_valid = '0;
    #1;
    chk("rx_busy", busy, 0);
    chk("rx_rvalid", resp_valid, 0);
    chk("rx_dpl", dp_left, 0);
    chk("rx_dpr", dp_right, 0);
    chk("rx_dps", dp_sub, 0);
    chk("rx_rdata", resp_data, 0);
    chk("rx_rid", resp_id, 0);
    step; step;
    reset_n = 1'b1;
    resp_ready = 1'b1;
    model_ptr = 0;
    for (int k = 0; k < 4; k++) begin
      step;
      chk("rx_no_resp", resp_valid, 0);
      chk("rx_idle", busy, 0);
    end
    resp_ready = 1'b0;
    do_op(4'b1010, 0, w, t0);
    chk("rx_ptr0", w, 1);

    // Randomized traffic
    for (int n = 0; n < 40; n++) begin
      rand_operands();
      m = NUM_REQ'($urandom_range(0, (1 << NUM_REQ) - 1));
      if (m == '0) begin
        req_valid = '0;
        #1;
        chk("rnd_none", req_ready, 0);
        step;
        chk("rnd_none_busy", busy, 0);
      end else begin
        do_op(m, $urandom_range(0, 3), w, t0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
